seq_multiplier8: RTL and testbench
==================================

Name: seq_multiplier8

Overview:
- Multi-cycle 8x8 shift-add multiplier; arithmetic inverse of the combinational 8-bit signed divider in the processor datapath.
- Serves the MUL and IMUL paths of the 8086-style ALU.
- Produces a 16-bit product plus an 8086-style overflow flag (CF/OF).
- Controller uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH. Only 8 is verified.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- signed_mode  input  1  1 = IMUL (two's complement), 0 = MUL (unsigned); latched at start
- multiplicand  input  8  operand A; latched at start
- multiplier  input  8  operand B; latched at start
- product  output  16  result; held until the next completed operation
- overflow  output  1  CF/OF; held with product
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when product/overflow update

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (any time, including mid-operation):
  - State = IDLE.
  - product = 0, overflow = 0, busy = 0, done = 0.
  - Internal accumulator, operand registers and counter cleared.
  - The aborted operation produces no done pulse.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - If start = 1 at edge k:
    - Latch the operands and signed_mode.
    - If signed_mode = 1, record neg = A[7] XOR B[7] and replace each negative operand with its magnitude (0 - x).
    - For -128 the magnitude 0x80 is treated as unsigned 128.
    - Accumulator = 0; counter = 8; busy = 1 from edge k; go to RUN.
  - If start = 0, stay in IDLE.
- RUN (edges k+1 .. k+8), one iteration per clock:
  - If the multiplier LSB = 1, add the multiplicand to the upper accumulator half using a 9-bit sum to keep the carry.
  - Shift {carry, accumulator, multiplier} right by 1.
  - Decrement the counter; after 8 iterations go to FIX.
- FIX (edge k+9):
  - product = neg ? (0 - raw16) : raw16.
  - overflow:
    - signed_mode = 1: overflow = (product[15:8] != {8{product[7]}}).
    - signed_mode = 0: overflow = (product[15:8] != 0).
  - done = 1 for exactly the following cycle; busy = 0; go to IDLE.
- Latency: start edge to done visible is 10 clocks; throughput is one operation per 10 clocks.
- start while busy = 1 is ignored: no latch, no queueing.
- start in the cycle done is high is accepted, since the FSM is already IDLE.
- Operand or signed_mode changes after the start edge do not affect the running operation.
- product and overflow change only at FIX or reset; they are stable at all other times.
- Full-width cases are exact:
  - 255*255 unsigned = 0xFE01.
  - -128*-128 = 0x4000.
  - -128*127 = 0xC080.

Optional Feature:
- Macro: MULT_ZERO_SKIP_EN.
- Defined:
  - In IDLE, if start = 1 and either operand is 0x00, skip RUN and go directly to FIX with raw16 = 0.
  - done is visible 2 clocks after the start edge; product = 0x0000, overflow = 0.
  - busy is high for exactly one cycle.
- Undefined:
  - Zero operands take the full 10-clock path with an identical result.
- Non-zero operands behave identically in both builds.

Test Plan:
- Unsigned: A=0xFF, B=0xFF, signed_mode=0, start pulse -> done 10 clocks later; product=0xFE01, overflow=1; busy high 9 cycles.
- Signed: A=0xFD (-3), B=0x07, signed_mode=1 -> product=0xFFEB (-21), overflow=0. Then A=0x80, B=0x80 -> product=0x4000, overflow=1.
- Start while busy: start at edge 0 with A=0x02, B=0x03; start again at edge 4 with A=0x10, B=0x10 -> single done, product=0x0006; second request ignored.
- Back-to-back: new start (A=0x0C, B=0x0A, unsigned) asserted during the done cycle -> accepted; second done 10 clocks later with product=0x0078, overflow=0.
- Reset mid-op: A=0x7F, B=0x7F signed; rst pulsed at edge k+5 -> immediate product=0, busy=0, no done pulse; a fresh op (0x7F*0x7F) then yields 0x3F01, overflow=1.
- Zero operand: A=0x00, B=0x5A, signed_mode=1 -> product=0x0000, overflow=0; done 2 clocks after start with MULT_ZERO_SKIP_EN defined, 10 clocks without.

Source files
------------

// File: rtl/seq_multiplier8.sv
// -----------------------------------------------------------------------------
// seq_multiplier8
// Multi-cycle 8x8 shift-add multiplier for the MUL/IMUL paths of the
// 8086-style ALU. It produces a 16-bit product and the CF/OF overflow flag,
// and uses a start/busy/done handshake.
//
// Signed operands are converted to magnitudes when the operation starts. The
// unsigned core then runs one add/shift iteration per clock. The sign is
// applied again in the FIX state.
//
// Optional build macro: MULT_ZERO_SKIP_EN. When it is defined, a zero operand
// skips the iteration phase and goes straight to FIX with a zero result.
// -----------------------------------------------------------------------------
module seq_multiplier8 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Magnitude of an operand. In signed mode, -128 becomes 0x80, which the
    // core then treats as unsigned 128.
    function automatic logic [WIDTH-1:0] operand_mag(input logic [WIDTH-1:0] x,
                                                     input logic             sm);
        logic [WIDTH-1:0] m;
        if (sm && x[WIDTH-1]) begin
            m = {WIDTH{1'b0}} - x;
        end else begin
            m = x;
        end
        return m;
    endfunction

    state_t               state_r;
    state_t               state_s;

    logic [WIDTH-1:0]     mcand_r;
    logic [WIDTH-1:0]     mplr_r;
    logic [WIDTH-1:0]     acc_hi_r;
    logic [CW-1:0]        cnt_r;
    logic                 neg_r;
    logic                 sm_r;

    logic [2*WIDTH-1:0]   product_r;
    logic                 overflow_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 zero_op_s;
    logic                 load_s;
    logic                 iter_s;
    logic                 fix_s;
    logic                 busy_s;
    logic                 done_s;
    logic [WIDTH:0]       sum_s;
    logic [2*WIDTH-1:0]   raw_s;
    logic [2*WIDTH-1:0]   fix_product_s;
    logic                 fix_ovf_s;

    // Detect a zero operand when the short-cut path is built in.
    always_comb begin
`ifdef MULT_ZERO_SKIP_EN
        if ((multiplicand == {WIDTH{1'b0}}) || (multiplier == {WIDTH{1'b0}})) begin
            zero_op_s = 1'b1;
        end else begin
            zero_op_s = 1'b0;
        end
`else
        zero_op_s = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic. A start request is seen only in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (zero_op_s) begin
                        state_s = ST_FIX;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CW'(1)) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIX: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control decode. Busy follows the next state, so it rises on the start edge.
    always_comb begin
        load_s = 1'b0;
        iter_s = 1'b0;
        fix_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s = start;
            end
            ST_RUN: begin
                iter_s = 1'b1;
            end
            ST_FIX: begin
                fix_s = 1'b1;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
        done_s = fix_s;
    end

    // One iteration adds the multiplicand to the upper half. The add uses a
    // 9-bit sum so that the carry is kept.
    always_comb begin
        if (mplr_r[0]) begin
            sum_s = {1'b0, acc_hi_r} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, acc_hi_r};
        end
    end

    // Apply the sign to the magnitude product, then derive CF/OF from the
    // final value.
    always_comb begin
        raw_s = {acc_hi_r, mplr_r};
        if (neg_r) begin
            fix_product_s = {(2*WIDTH){1'b0}} - raw_s;
        end else begin
            fix_product_s = raw_s;
        end
        if (sm_r) begin
            fix_ovf_s = (fix_product_s[2*WIDTH-1:WIDTH] != {WIDTH{fix_product_s[WIDTH-1]}});
        end else begin
            fix_ovf_s = (fix_product_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
        end
    end

    // Operand latch and the shift-add datapath: {carry, acc_hi, mplr} >> 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplr_r   <= {WIDTH{1'b0}};
            acc_hi_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            neg_r    <= 1'b0;
            sm_r     <= 1'b0;
        end else if (load_s) begin
            sm_r     <= signed_mode;
            neg_r    <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            mcand_r  <= operand_mag(multiplicand, signed_mode);
            acc_hi_r <= {WIDTH{1'b0}};
            cnt_r    <= CW'(WIDTH);
            if (zero_op_s) begin
                mplr_r <= {WIDTH{1'b0}};
            end else begin
                mplr_r <= operand_mag(multiplier, signed_mode);
            end
        end else if (iter_s) begin
            acc_hi_r <= sum_s[WIDTH:1];
            mplr_r   <= {sum_s[0], mplr_r[WIDTH-1:1]};
            cnt_r    <= cnt_r - CW'(1);
        end else begin
            mcand_r  <= mcand_r;
            mplr_r   <= mplr_r;
            acc_hi_r <= acc_hi_r;
            cnt_r    <= cnt_r;
            neg_r    <= neg_r;
            sm_r     <= sm_r;
        end
    end

    // Registered outputs. Product and flag change only in FIX or on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product_r  <= {(2*WIDTH){1'b0}};
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
            if (fix_s) begin
                product_r  <= fix_product_s;
                overflow_r <= fix_ovf_s;
            end else begin
                product_r  <= product_r;
                overflow_r <= overflow_r;
            end
        end
    end

    assign product  = product_r;
    assign overflow = overflow_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_seq_multiplier8.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier8
// Directed self-checking bench for seq_multiplier8. Expected values are
// computed by hand. Define MULT_ZERO_SKIP_EN when building the bench to
// match a DUT built with zero skip.
// -----------------------------------------------------------------------------
module tb_seq_multiplier8;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [15:0] product;
    logic        overflow;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    seq_multiplier8 dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .overflow     (overflow),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse. On return the start edge has just passed.
    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic sm);
        multiplicand = a;
        multiplier   = b;
        signed_mode  = sm;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // Count the edges from now until done is seen, and the busy cycles before it.
    // lat stays -1 if done never arrives within the budget.
    task automatic wait_done(output int lat, output int bcnt);
        int i;
        lat  = -1;
        bcnt = 0;
        i    = 0;
        while ((lat < 0) && (i < 30)) begin
            if (done) begin
                lat = i;
            end else begin
                if (busy) bcnt++;
                tick();
                i++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0;
        multiplicand = 8'h00; multiplier = 8'h00;
        tick(); tick();
        checks++;
        if (product !== 16'h0000 || overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: product=%h ovf=%b busy=%b done=%b, expected 0000/0/0/0",
                     product, overflow, busy, done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int lat, bc;
        do_start(8'hFF, 8'hFF, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_rise: busy=%b expected 1", busy);
        end
        wait_done(lat, bc);
        checks++;
        if (lat !== 9) begin
            errors++; $display("FAIL unsigned_latency: edges=%0d expected 9", lat);
        end
        checks++;
        if (bc !== 9) begin
            errors++; $display("FAIL unsigned_busy_cycles: %0d expected 9", bc);
        end
        checks++;
        if (product !== 16'hFE01 || overflow !== 1'b1) begin
            errors++; $display("FAIL unsigned_ff_ff: product=%h ovf=%b expected fe01/1", product, overflow);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL done_one_cycle: done=%b expected 0", done);
        end
        // Unsigned flag depends only on the upper byte, not on bit 7.
        do_start(8'h10, 8'h0F, 1'b0);
        wait_done(lat, bc);
        checks++;
        if (product !== 16'h00F0 || overflow !== 1'b0) begin
            errors++; $display("FAIL unsigned_10_0f: product=%h ovf=%b expected 00f0/0", product, overflow);
        end
        do_start(8'h80, 8'h80, 1'b0);
        wait_done(lat, bc);
        checks++;
        if (product !== 16'h4000 || overflow !== 1'b1) begin
            errors++; $display("FAIL unsigned_80_80: product=%h ovf=%b expected 4000/1", product, overflow);
        end
    endtask

    task automatic test_signed();
        int lat, bc;
        logic [7:0]  a_tab   [5];
        logic [7:0]  b_tab   [5];
        logic [15:0] p_tab   [5];
        logic        o_tab   [5];
        a_tab = '{8'hFD, 8'h80, 8'h80, 8'hFF, 8'hFF};
        b_tab = '{8'h07, 8'h80, 8'h7F, 8'hFF, 8'h01};
        p_tab = '{16'hFFEB, 16'h4000, 16'hC080, 16'h0001, 16'hFFFF};
        o_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            do_start(a_tab[i], b_tab[i], 1'b1);
            wait_done(lat, bc);
            checks++;
            if (lat !== 9 || product !== p_tab[i] || overflow !== o_tab[i]) begin
                errors++;
                $display("FAIL signed_%h_%h: product=%h ovf=%b lat=%0d expected %h/%b lat 9",
                         a_tab[i], b_tab[i], product, overflow, lat, p_tab[i], o_tab[i]);
            end
        end
    endtask

    task automatic test_hold();
        int lat, bc;
        do_start(8'h03, 8'h05, 1'b0);
        multiplicand = 8'hAA; multiplier = 8'h55; signed_mode = 1'b1;
        tick(); tick(); tick(); tick();
        checks++;
        if (product !== 16'hFFFF || overflow !== 1'b0) begin
            errors++; $display("FAIL hold_midop: product=%h ovf=%b expected ffff/0", product, overflow);
        end
        wait_done(lat, bc);
        checks++;
        if (product !== 16'h000F || overflow !== 1'b0) begin
            errors++; $display("FAIL operand_change: product=%h ovf=%b expected 000f/0", product, overflow);
        end
    endtask

    task automatic test_start_while_busy();
        int first, cnt;
        do_start(8'h02, 8'h03, 1'b0);             // edge 0
        tick(); tick(); tick();                   // edges 1..3
        multiplicand = 8'h10; multiplier = 8'h10; start = 1'b1;
        tick();                                   // edge 4
        start = 1'b0;
        first = -1; cnt = 0;
        for (int i = 5; i < 30; i++) begin
            tick();
            if (done) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (cnt !== 1 || first !== 9) begin
            errors++; $display("FAIL busy_start_ignored: done pulses=%0d first=%0d expected 1 at 9", cnt, first);
        end
        checks++;
        if (product !== 16'h0006) begin
            errors++; $display("FAIL busy_start_product: product=%h expected 0006", product);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_start(8'h05, 8'h03, 1'b0);
        wait_done(lat, bc);
        checks++;
        if (product !== 16'h000F) begin
            errors++; $display("FAIL b2b_first: product=%h expected 000f", product);
        end
        do_start(8'h0C, 8'h0A, 1'b0);              // start during the done cycle
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: busy=%b done=%b expected 1/0", busy, done);
        end
        wait_done(lat, bc);
        checks++;
        if (lat !== 9 || product !== 16'h0078 || overflow !== 1'b0) begin
            errors++; $display("FAIL b2b_second: lat=%0d product=%h ovf=%b expected 9/0078/0", lat, product, overflow);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, cnt;
        do_start(8'h7F, 8'h7F, 1'b1);              // edge k
        tick(); tick(); tick(); tick();            // edges k+1..k+4
        #2 rst = 1'b1;
        #1;
        checks++;
        if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL midop_reset: product=%h busy=%b done=%b ovf=%b expected 0000/0/0/0",
                               product, busy, done, overflow);
        end
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) cnt++;
        end
        checks++;
        if (cnt !== 0) begin
            errors++; $display("FAIL aborted_done: pulses=%0d expected 0", cnt);
        end
        do_start(8'h7F, 8'h7F, 1'b1);
        wait_done(lat, bc);
        checks++;
        if (lat !== 9 || product !== 16'h3F01 || overflow !== 1'b1) begin
            errors++; $display("FAIL after_reset_op: lat=%0d product=%h ovf=%b expected 9/3f01/1", lat, product, overflow);
        end
    endtask

    task automatic test_zero();
        int lat, bc, exp_lat, exp_bc;
`ifdef MULT_ZERO_SKIP_EN
        exp_lat = 1; exp_bc = 1;
`else
        exp_lat = 9; exp_bc = 9;
`endif
        do_start(8'h00, 8'h5A, 1'b1);
        wait_done(lat, bc);
        checks++;
        if (lat !== exp_lat || bc !== exp_bc) begin
            errors++; $display("FAIL zero_timing: lat=%0d busy=%0d expected %0d/%0d", lat, bc, exp_lat, exp_bc);
        end
        checks++;
        if (product !== 16'h0000 || overflow !== 1'b0) begin
            errors++; $display("FAIL zero_result: product=%h ovf=%b expected 0000/0", product, overflow);
        end
        do_start(8'hC3, 8'h00, 1'b0);
        wait_done(lat, bc);
        checks++;
        if (lat !== exp_lat || product !== 16'h0000 || overflow !== 1'b0) begin
            errors++; $display("FAIL zero_b: lat=%0d product=%h ovf=%b expected %0d/0000/0", lat, product, overflow, exp_lat);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_hold();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
